// File: rtl/alu_iter.sv
// Execute-stage ALU: registered single-cycle ops, 32-cycle shift-add MUL with valid/ready backpressure.
// Define ALU_FAST_MUL_EN to replace the iterative MUL with a single-cycle combinational multiply.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_ADD = 3'b111;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             accept;

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND: alu_res = data1_i & data2_i;
      OP_XOR: alu_res = data1_i ^ data2_i;
      OP_SLL: alu_res = data1_i << data2_i[4:0];
      OP_OR:  alu_res = data1_i | data2_i;
      OP_SRA: alu_res = $unsigned($signed(data1_i) >>> data2_i[4:0]);
`ifdef ALU_FAST_MUL_EN
      OP_MUL: alu_res = data1_i * data2_i;
`else
      OP_MUL: alu_res = '0;
`endif
      OP_SUB: alu_res = data1_i - data2_i;
      OP_ADD: alu_res = data1_i + data2_i;
      default: alu_res = '0;
    endcase
  end

  assign accept  = valid_i && ready_o && !flush_i;
  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign valid_o = valid_q;

`ifdef ALU_FAST_MUL_EN

  assign ready_o = 1'b1;

  always_comb begin
    data_d  = data_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    if (accept) begin
      data_d  = alu_res;
      zero_d  = (alu_res == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

`else

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_sum;

  assign ready_o = (state_q == IDLE);
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (ALUCtrl_i == OP_MUL) begin
              mcand_d  = data1_i;
              mplier_d = data2_i;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = MUL_BUSY;
            end else begin
              data_d  = alu_res;
              zero_d  = (alu_res == '0);
              valid_d = 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          // One multiplier bit per edge; the last edge publishes the sum directly.
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            data_d  = acc_sum;
            zero_d  = (acc_sum == '0);
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

`endif

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, flush_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i, data2_i;
  logic        ready_o, zero_o, valid_o;
  logic [31:0] data_o;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .data_o(data_o), .zero_o(zero_o), .valid_o(valid_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return a << b[4:0];
      3'd3: return a | b;
      3'd4: return sa >>> b[4:0];
      3'd5: return a * b;
      3'd6: return a - b;
      default: return a + b;
    endcase
  endfunction

  // Reference model: what each edge must produce, from the operation rules.
  bit          m_on = 1'b0;
  int          m_busy = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_pend = '0;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_on = 1'b1; m_busy = 0; m_data = '0; m_valid = 1'b0;
    end else if (m_on) begin
      m_valid = 1'b0;
      if (flush_i) begin
        m_busy = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1'b1;
          m_data  = m_pend;
        end
      end else if (valid_i) begin
`ifndef ALU_FAST_MUL_EN
        if (ALUCtrl_i == 3'd5) begin
          m_busy = 32;
          m_pend = ref_op(ALUCtrl_i, data1_i, data2_i);
        end else begin
`else
        begin
`endif
          m_valid = 1'b1;
          m_data  = ref_op(ALUCtrl_i, data1_i, data2_i);
        end
      end
    end
  end

  logic [32:0] res_q[$];
  int          run = 0, max_run = 0, nvalid = 0;

  always @(posedge clk) begin
    #2;
    if (m_on) begin
      chk("valid_o", {63'd0, valid_o}, {63'd0, m_valid});
      chk("ready_o", {63'd0, ready_o}, {63'd0, (m_busy == 0)});
      chk("data_o", {32'd0, data_o}, {32'd0, m_data});
      chk("zero_o", {63'd0, zero_o}, {63'd0, (m_data == 32'd0)});
    end
    if (valid_o === 1'b1) begin
      nvalid++;
      run++;
      if (run > max_run) max_run = run;
      res_q.push_back({zero_o, data_o});
    end else begin
      run = 0;
    end
  end

  function automatic logic [63:0] pop_res();
    if (res_q.size() == 0) return 64'hDEAD_0000_DEAD_0000;
    return {31'd0, res_q.pop_front()};
  endfunction

  // Called at a negedge; holds the op until accepted, returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL issue_timeout: got ready_o low for %0d cycles expected under 100", n);
    end
    @(negedge clk);
  endtask

  initial begin
    int lowc;
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1; ALUCtrl_i = 3'd7; data1_i = 32'd5; data2_i = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0; valid_i = 1'b0;
    chk("rst_no_valid", nvalid, 0);
    chk("rst_data", {32'd0, data_o}, 64'd0);
    chk("rst_zero", {63'd0, zero_o}, 64'd1);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);

    // back-to-back single-cycle ops
    res_q.delete(); max_run = 0;
    issue(3'd7, 32'hFFFF_FFFF, 32'd1);
    issue(3'd6, 32'd3, 32'd3);
    issue(3'd4, 32'h8000_0000, 32'd4);
    issue(3'd2, 32'd1, 32'd31);
    issue(3'd1, 32'h0000_F0F0, 32'h0000_0FF0);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_add", pop_res(), {31'd0, 1'b1, 32'h0000_0000});
    chk("b2b_sub", pop_res(), {31'd0, 1'b1, 32'h0000_0000});
    chk("b2b_sra", pop_res(), {31'd0, 1'b0, 32'hF800_0000});
    chk("b2b_sll", pop_res(), {31'd0, 1'b0, 32'h8000_0000});
    chk("b2b_xor", pop_res(), {31'd0, 1'b0, 32'h0000_FF00});
    chk("b2b_run", max_run, 5);

    // MUL latency and the next accept right after
    res_q.delete();
    issue(3'd5, 32'hFFFF_FFFF, 32'd3);
    valid_i = 1'b0;
    lowc = 0;
    while (ready_o !== 1'b1 && lowc < 100) begin
      lowc++;
      @(negedge clk);
    end
`ifdef ALU_FAST_MUL_EN
    chk("mul_ready_low", lowc, 0);
`else
    chk("mul_ready_low", lowc, 32);
`endif
    chk("mul_valid", {63'd0, valid_o}, 64'd1);
    chk("mul_data", {32'd0, data_o}, {32'd0, 32'hFFFF_FFFD});
    issue(3'd7, 32'd2, 32'd3);
    valid_i = 1'b0;
    chk("post_mul_add_valid", {63'd0, valid_o}, 64'd1);
    chk("post_mul_add_data", {32'd0, data_o}, 64'd5);

    // backpressure: ADD held while MUL busy
    repeat (2) @(negedge clk);
    res_q.delete();
    issue(3'd5, 32'd12, 32'd10);
    issue(3'd7, 32'd1, 32'd1);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_count", res_q.size(), 2);
    chk("bp_first", pop_res(), {31'd0, 1'b0, 32'd120});
    chk("bp_second", pop_res(), {31'd0, 1'b0, 32'd2});

    // flush mid-MUL
    res_q.delete();
    issue(3'd5, 32'd7, 32'd6);
    valid_i = 1'b0;
    repeat (8) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_ready", {63'd0, ready_o}, 64'd1);
`ifdef ALU_FAST_MUL_EN
    chk("flush_data", {32'd0, data_o}, 64'd42);
`else
    chk("flush_data", {32'd0, data_o}, 64'd2);
    chk("flush_valid", {63'd0, valid_o}, 64'd0);
`endif
    repeat (40) @(negedge clk);
`ifdef ALU_FAST_MUL_EN
    chk("flush_results", res_q.size(), 1);
`else
    chk("flush_results", res_q.size(), 0);
`endif
    res_q.delete();
    issue(3'd5, 32'd7, 32'd6);
    valid_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("mul_after_flush", pop_res(), {31'd0, 1'b0, 32'd42});

    // MUL whose low 32 bits are zero
    res_q.delete();
    issue(3'd5, 32'h0001_0000, 32'h0001_0000);
    valid_i = 1'b0;
`ifdef ALU_FAST_MUL_EN
    chk("fast_mul_valid", {63'd0, valid_o}, 64'd1);
    chk("fast_mul_data", {32'd0, data_o}, 64'd0);
    chk("fast_mul_zero", {63'd0, zero_o}, 64'd1);
`else
    repeat (40) @(negedge clk);
    chk("mul_zero_res", pop_res(), {31'd0, 1'b1, 32'd0});
`endif

    // randomized traffic with occasional flushes; model checks every cycle
    repeat (800) begin
      @(negedge clk);
      valid_i   = ($urandom_range(0, 9) < 7);
      flush_i   = ($urandom_range(0, 29) == 0);
      ALUCtrl_i = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: data1_i = 32'd0;
        1: data1_i = 32'hFFFF_FFFF;
        default: data1_i = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: data2_i = 32'($urandom_range(0, 40));
        1: data2_i = 32'h8000_0000;
        default: data2_i = $urandom;
      endcase
    end
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Execute-stage ALU that consumes the 3-bit operation code produced by the ALU control decoder and the two 32-bit operands from the register/immediate mux. Single-cycle operations return a registered result one cycle after acceptance. MUL runs as an iterative radix-2 shift-add unit over 32 cycles and back-pressures the pipeline through a valid/ready handshake. Output feeds the EX/MEM pipeline register and the hazard unit.

## Interface

- WIDTH, 32: operand and result width; must stay 32. The iteration counter is 5 bits.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous and active-high.
- valid_i  input  1  operands and operation code are valid this cycle.
- ready_o  output  1  block can accept a new operation this cycle.
- flush_i  input  1  abort any in-flight operation; pipeline flush.
- ALUCtrl_i  input  3  operation code:
  - 000 AND
  - 001 XOR
  - 010 SLL
  - 011 OR
  - 100 SRA
  - 101 MUL
  - 110 SUB
  - 111 ADD
- data1_i  input  32  operand A.
- data2_i  input  32  operand B; shift amount is data2_i[4:0].
- data_o  output  32  registered result.
- zero_o  output  1  registered, equals (data_o == 0).
- valid_o  output  1  one-cycle pulse: data_o/zero_o hold a new result.

## Operation

- **Accept:** an operation is accepted on an edge where valid_i && ready_o && !flush_i.
- **States:** IDLE and MUL_BUSY.
  - ready_o = (state == IDLE).
- **Non-MUL in IDLE:**
  - On accept, compute the result and load it into data_o/zero_o.
  - valid_o = 1 for the following cycle; state stays IDLE.
  - Back-to-back accepts are allowed, giving one result per cycle.
- **Operation rules:**
  - ADD and SUB wrap modulo 2^32.
  - SLL and SRA shift by data2_i[4:0]. SRA replicates data1_i[31].
  - AND, OR and XOR are bitwise.
- **MUL in IDLE:**
  - On accept, latch multiplicand = data1_i and multiplier = data2_i, clear the accumulator and the counter, and go to MUL_BUSY.
  - valid_o = 0 on this edge; data_o holds its previous value.
- **MUL_BUSY, each edge:**
  - If multiplier[0] is set, acc += multiplicand (mod 2^32).
  - Shift the multiplicand left by 1 and the multiplier right by 1 (logical), and increment the counter.
  - When counter == 31 on the edge, load the final accumulator into data_o/zero_o, set valid_o for one cycle and return to IDLE.
  - The result is the low 32 bits of the product, identical for signed and unsigned operands.
- **Flush:**
  - flush_i = 1 forces IDLE and clears valid_o and the counter. No result is produced. data_o keeps its last value.
  - A valid_i asserted in the same cycle is dropped.
- **Inputs in MUL_BUSY:** valid_i is ignored (ready_o = 0). Operand and opcode changes have no effect.
- **Priority:** rst_i > flush_i > accept/iteration.

## Timing

- **Reset values:** state IDLE, data_o = 0, zero_o = 1, valid_o = 0, ready_o = 1 (from the cycle after the reset edge), counter = 0.
- **Non-MUL latency:** accept at edge E0, result visible with valid_o = 1 between E0 and E1.
- **MUL latency:**
  - Accept at E0; iterations occur on E1..E32.
  - Result and valid_o = 1 are visible between E32 and E33.
  - ready_o = 0 from E0 to E32 and returns to 1 after E32.
  - The next operation can be accepted at E33 at the earliest.
- **valid_o:** is never high for two consecutive cycles due to the same operation.
- **Reset or flush mid-MUL:** takes effect on that edge; ready_o = 1 in the next cycle.

## Configuration

- **Macro:** ALU_FAST_MUL_EN.
- **Defined:**
  - MUL uses a combinational 32x32 multiply (low 32 bits) and behaves exactly like a non-MUL operation, with 1-cycle latency.
  - MUL_BUSY and the iteration registers are not built; ready_o = 1 in every cycle after reset.
- **Undefined:** iterative 32-cycle MUL as described above.
- **Both builds:** results and reset values are identical; only the MUL latency and ready_o differ.

## Test plan

- **Reset:** hold rst_i for 2 cycles with valid_i = 1 and ADD of 5 and 7 -> no valid_o pulse; data_o = 0, zero_o = 1, ready_o = 1 after release.
- **Back-to-back single-cycle ops:** one op per cycle, ADD 0xFFFFFFFF+1, SUB 3-3, SRA 0x80000000>>4, SLL 1<<31, XOR 0xF0F0 ^ 0x0FF0:
  - data_o in order: 0x00000000 (zero_o = 1), 0x00000000 (zero_o = 1), 0xF8000000, 0x80000000, 0x0000FF00.
  - valid_o high on 5 consecutive cycles.
- **Iterative MUL (macro off):** MUL 0xFFFFFFFF * 3 -> ready_o low 32 cycles, valid_o pulse at cycle 32 with data_o = 0xFFFFFFFD; next ADD accepted at cycle 33.
- **Busy back-pressure:** valid_i held high with ADD 1+1 during MUL 12*10 -> ADD is not accepted until ready_o returns; results are 120 then 2, in that order.
- **Flush mid-MUL:** flush_i at cycle 10 of MUL 7*6 -> no valid_o, data_o unchanged, ready_o = 1 next cycle; a following MUL 7*6 yields 42.
- **Fast MUL (ALU_FAST_MUL_EN defined):** MUL 0x00010000 * 0x00010000 -> valid_o next cycle, data_o = 0, zero_o = 1, ready_o never drops.
